// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronizes and debounces the 10 slide switches and
// 4 push buttons that feed the data memory's IO read window.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   raw_switches  asynchronous slide-switch pins (1 = on)
//   raw_buttons   asynchronous push-button pins (active low if BUTTON_ACTIVE_LOW)
//   io_input_bus  conditioned levels, [9:0] switches, [13:10] buttons, 1 = active
//   press_pulse   one-cycle pulse per button when a press is accepted
module io_input_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int CNT_WIDTH         = 20,
    parameter int BUTTON_ACTIVE_LOW = 1,
    parameter int SWITCH_DEBOUNCE   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  raw_switches,
    input  logic [3:0]  raw_buttons,
    output logic [13:0] io_input_bus,
    output logic [3:0]  press_pulse
);

    localparam int NUM_SW  = 10;
    localparam int NUM_BTN = 4;
    localparam int NB      = NUM_SW + NUM_BTN;

    // Last count value before a new level is accepted; the counter never
    // goes beyond it, so no wrap handling is needed.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Normalization: after this point every bit reads 1 = active.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_norm;
    logic [NB-1:0]      norm;

    assign btn_norm = (BUTTON_ACTIVE_LOW != 0) ? ~raw_buttons : raw_buttons;
    assign norm     = {btn_norm, raw_switches};

    // ------------------------------------------------------------------
    // Synchronizer chain, SYNC_STAGES flops per bit.
    // ------------------------------------------------------------------
    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] sync_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= norm;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-bit debounce filter.
    // ------------------------------------------------------------------
    logic [NB-1:0]        stable_q;
    logic [NB-1:0]        stable_d;
    logic [CNT_WIDTH-1:0] cnt_q [NB];
    logic [CNT_WIDTH-1:0] cnt_d [NB];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if ((i < NUM_SW) && (SWITCH_DEBOUNCE == 0)) begin
                // Bypassed switches follow the synchronizer directly.
                stable_d[i] = sync_w[i];
            end else if (sync_w[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_w[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Press edge detection on the debounced button levels.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] prev_btn_q;
    logic [NUM_BTN-1:0] prev_btn_d;
    logic [NUM_BTN-1:0] pulse_q;
    logic [NUM_BTN-1:0] pulse_d;

    assign btn_stable = stable_q[NB-1:NUM_SW];
    assign prev_btn_d = btn_stable;
    assign pulse_d    = btn_stable & ~prev_btn_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q   <= '0;
            prev_btn_q <= '0;
            pulse_q    <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q   <= stable_d;
            prev_btn_q <= prev_btn_d;
            pulse_q    <= pulse_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io_input_bus = stable_q;
    assign press_pulse  = pulse_q;

endmodule
